// File: rtl/eq_gain_scheduler.sv
`default_nettype none
//============================================================================
// Module      : eq_gain_scheduler
// Description : Owns the equalizer band gains and is the only master on the
//               equalizer register port. The host programs target gains over
//               an Avalon-MM slave. On each FFT frame boundary the block
//               sweeps every band, moves the current gain one step toward its
//               target, and writes any changed gain to the equalizer.
//
// Ports       : system_clk, reset          clock / synchronous active-high reset
//               host_cs, host_write,       Avalon-MM slave (read latency 1)
//               host_read, host_address,
//               host_writedata, host_readdata
//               frame_done                 one-cycle frame-end pulse
//               eq_chipselect, eq_write,   equalizer register master port
//               eq_address, eq_writedata
//               busy                       sweep in progress
//
// Revision    : 1.0  initial release
//============================================================================
module eq_gain_scheduler #(
    parameter int NUM_BANDS = 12,
    parameter int GAIN_W    = 5,
    parameter int UNITY     = 13,
    parameter int MAX_GAIN  = 28,
    parameter int STEP      = 1
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       host_cs,
    input  logic       host_write,
    input  logic       host_read,
    input  logic [3:0] host_address,
    input  logic [7:0] host_writedata,
    output logic [7:0] host_readdata,
    input  logic       frame_done,
    output logic       eq_chipselect,
    output logic       eq_write,
    output logic [3:0] eq_address,
    output logic [7:0] eq_writedata,
    output logic       busy
);

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] c_CTRL_ADDR = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] c_STAT_ADDR = ADDR_W'(13);
    localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(NUM_BANDS - 1);
    localparam logic [ADDR_W-1:0] c_NBANDS    = ADDR_W'(NUM_BANDS);

    localparam logic [GAIN_W-1:0] c_UNITY = GAIN_W'(UNITY);
    localparam logic [GAIN_W-1:0] c_MAX   = GAIN_W'(MAX_GAIN);
    localparam logic [GAIN_W-1:0] c_STEP  = GAIN_W'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_pending;
    logic              r_ramp_en;
    logic [GAIN_W-1:0] r_tgt [NUM_BANDS];
    logic [GAIN_W-1:0] r_cur [NUM_BANDS];

    logic              w_host_wr;
    logic              w_host_rd;
    logic [GAIN_W-1:0] w_wdata_gain;
    logic [GAIN_W-1:0] w_wr_gain;
    logic              w_force;
    logic              w_event;
    logic [GAIN_W-1:0] w_cur_sel;
    logic [GAIN_W-1:0] w_tgt_sel;
    logic [GAIN_W-1:0] w_rd_tgt;
    logic              w_settled;
    logic              w_changed;
    logic [GAIN_W-1:0] w_next;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_wdata;

    assign w_host_wr      = host_cs && host_write;
    assign w_host_rd      = host_cs && host_read;
    assign w_wdata_gain   = host_writedata[GAIN_W-1:0];
    assign w_wr_gain      = (w_wdata_gain > c_MAX) ? c_MAX : w_wdata_gain;
    assign w_unused_wdata = &{1'b0, host_writedata[DATA_W-1:GAIN_W]};

    // force_sweep is a write-1 strobe; it is never stored, only acted on
    // in the cycle of the host write.
    assign w_force = w_host_wr && (host_address == c_CTRL_ADDR) && host_writedata[1];
    assign w_event = frame_done || w_force;

    // Band selection by compare-and-mux keeps every array index in range.
    always_comb begin
        w_cur_sel = '0;
        w_tgt_sel = '0;
        w_rd_tgt  = '0;
        w_settled = 1'b1;
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (r_idx == ADDR_W'(i)) begin
                w_cur_sel = r_cur[i];
                w_tgt_sel = r_tgt[i];
            end
            if (host_address == ADDR_W'(i)) begin
                w_rd_tgt = r_tgt[i];
            end
            if (r_cur[i] != r_tgt[i]) begin
                w_settled = 1'b0;
            end
        end
    end

    // Next gain for the band under scan: one step toward target, clamped so
    // it lands exactly on target rather than overshooting.
    always_comb begin
        w_changed = (w_cur_sel != w_tgt_sel);
        w_next    = w_tgt_sel;
        if (r_ramp_en) begin
            if (w_cur_sel < w_tgt_sel) begin
                if ((w_tgt_sel - w_cur_sel) > c_STEP) begin
                    w_next = w_cur_sel + c_STEP;
                end
            end else begin
                if ((w_cur_sel - w_tgt_sel) > c_STEP) begin
                    w_next = w_cur_sel - c_STEP;
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        if (host_address < c_NBANDS) begin
            w_rd_data = {{(DATA_W-GAIN_W){1'b0}}, w_rd_tgt};
        end else if (host_address == c_CTRL_ADDR) begin
            w_rd_data = {{(DATA_W-1){1'b0}}, r_ramp_en};
        end else if (host_address == c_STAT_ADDR) begin
            w_rd_data = {{(DATA_W-3){1'b0}}, w_settled, r_pending, busy};
        end
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_pending     <= 1'b0;
            r_ramp_en     <= 1'b1;
            host_readdata <= '0;
            eq_chipselect <= 1'b0;
            eq_write      <= 1'b0;
            eq_address    <= '0;
            eq_writedata  <= '0;
            busy          <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_tgt[i] <= c_UNITY;
                r_cur[i] <= c_UNITY;
            end
        end else begin
            if (w_host_rd) begin
                host_readdata <= w_rd_data;
            end

            if (w_host_wr) begin
                for (int i = 0; i < NUM_BANDS; i++) begin
                    if (host_address == ADDR_W'(i)) begin
                        r_tgt[i] <= w_wr_gain;
                    end
                end
                if (host_address == c_CTRL_ADDR) begin
                    r_ramp_en <= host_writedata[0];
                end
            end

            // Equalizer strobes are single-cycle; address/data hold.
            eq_chipselect <= 1'b0;
            eq_write      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_event || r_pending) begin
                        r_state   <= ST_SCAN;
                        r_idx     <= '0;
                        r_pending <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (w_event) begin
                        r_pending <= 1'b1;
                    end
                    if (w_changed) begin
                        for (int i = 0; i < NUM_BANDS; i++) begin
                            if (r_idx == ADDR_W'(i)) begin
                                r_cur[i] <= w_next;
                            end
                        end
                        eq_chipselect <= 1'b1;
                        eq_write      <= 1'b1;
                        eq_address    <= r_idx;
                        eq_writedata  <= {{(DATA_W-GAIN_W){1'b0}}, w_next};
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                ST_FINISH: begin
                    // Lets the write for the last band leave the port.
                    if (w_event) begin
                        r_pending <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eq_gain_scheduler.sv
`default_nettype none
//============================================================================
// Module      : tb_eq_gain_scheduler
// Description : Directed scoreboard bench for eq_gain_scheduler. Expected
//               equalizer writes and host read data are queued when stimulus
//               is issued; a monitor pops and compares when the DUT presents
//               them.
// Revision    : 1.0  initial release
//============================================================================
module tb_eq_gain_scheduler;

    logic       system_clk = 1'b0;
    logic       reset      = 1'b1;
    logic       host_cs    = 1'b0;
    logic       host_write = 1'b0;
    logic       host_read  = 1'b0;
    logic [3:0] host_address   = '0;
    logic [7:0] host_writedata = '0;
    logic [7:0] host_readdata;
    logic       frame_done = 1'b0;
    logic       eq_chipselect;
    logic       eq_write;
    logic [3:0] eq_address;
    logic [7:0] eq_writedata;
    logic       busy;

    always #5 system_clk = ~system_clk;

    eq_gain_scheduler dut (
        .system_clk     (system_clk),
        .reset          (reset),
        .host_cs        (host_cs),
        .host_write     (host_write),
        .host_read      (host_read),
        .host_address   (host_address),
        .host_writedata (host_writedata),
        .host_readdata  (host_readdata),
        .frame_done     (frame_done),
        .eq_chipselect  (eq_chipselect),
        .eq_write       (eq_write),
        .eq_address     (eq_address),
        .eq_writedata   (eq_writedata),
        .busy           (busy)
    );

    logic [11:0] wr_q [$];   // {addr, data}
    logic [7:0]  rd_q [$];
    int  n_tests   = 0;
    int  n_fail    = 0;
    int  sweeps    = 0;
    int  busy_run  = 0;
    bit  prev_busy = 1'b0;
    bit  chk_busy  = 1'b1;
    bit  rd_seen   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge system_clk);
        #1;
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        host_cs = 1'b1; host_write = 1'b1; host_address = a; host_writedata = d;
        tick();
        host_cs = 1'b0; host_write = 1'b0;
    endtask

    task automatic host_rd(input logic [3:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        host_cs = 1'b1; host_read = 1'b1; host_address = a;
        tick();
        host_cs = 1'b0; host_read = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    // Wait until busy has stayed low for three cycles (bounded).
    task automatic wait_quiet();
        int quiet = 0;
        int cyc   = 0;
        while (quiet < 3 && cyc < 300) begin
            @(negedge system_clk);
            if (busy) quiet = 0; else quiet++;
            cyc++;
        end
        if (quiet < 3) begin
            n_tests++; n_fail++;
            $display("FAIL wait_quiet: busy still high after %0d cycles", cyc);
        end
        tick();
    endtask

    // Read-strobe capture (the DUT samples at the same edge).
    initial forever begin
        @(posedge system_clk);
        rd_seen = host_cs && host_read;
    end

    // Monitor: equalizer writes, read responses, sweep length.
    initial forever begin
        @(negedge system_clk);
        if (eq_chipselect && eq_write) begin
            if (wr_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL eq_write_unexpected: got addr %0d data %0d, expected none",
                         eq_address, eq_writedata);
            end else begin
                check("eq_write", {20'd0, eq_address, eq_writedata}, {20'd0, wr_q.pop_front()});
            end
        end
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL readdata_unexpected: got 0x%0h", host_readdata);
            end else begin
                check("host_readdata", {24'd0, host_readdata}, {24'd0, rd_q.pop_front()});
            end
        end
        if (busy) begin
            if (!prev_busy) sweeps++;
            busy_run++;
        end else if (prev_busy) begin
            if (chk_busy) check("busy_length", busy_run, 13);
            busy_run = 0;
        end
        prev_busy = busy;
    end

    initial begin
        int s0;

        // Reset state
        tick(); tick();
        check("rst_eq_cs",    {31'd0, eq_chipselect}, 0);
        check("rst_eq_write", {31'd0, eq_write}, 0);
        check("rst_eq_addr",  {28'd0, eq_address}, 0);
        check("rst_eq_data",  {24'd0, eq_writedata}, 0);
        check("rst_busy",     {31'd0, busy}, 0);
        check("rst_readdata", {24'd0, host_readdata}, 0);
        reset = 1'b0;
        tick();

        // Idle sweep: no writes, settled status
        host_rd(4'd13, 8'h04);
        host_rd(4'd0,  8'd13);
        host_rd(4'd12, 8'h01);
        host_rd(4'd14, 8'h00);
        pulse_frame();
        wait_quiet();
        host_rd(4'd13, 8'h04);

        // Ramp band 3 toward 16, one step per frame
        host_wr(4'd3, 8'd16);
        exp_wr(4'd3, 8'd14); pulse_frame(); wait_quiet();
        exp_wr(4'd3, 8'd15); pulse_frame(); wait_quiet();
        exp_wr(4'd3, 8'd16); pulse_frame(); wait_quiet();
        pulse_frame(); wait_quiet();
        host_rd(4'd13, 8'h04);
        host_rd(4'd3,  8'd16);

        // Direct mode with saturation
        host_wr(4'd12, 8'h00);
        host_wr(4'd0,  8'd0);
        host_wr(4'd11, 8'd31);
        host_rd(4'd11, 8'd28);
        host_rd(4'd12, 8'h00);
        exp_wr(4'd0, 8'd0);
        exp_wr(4'd11, 8'd28);
        pulse_frame(); wait_quiet();
        host_rd(4'd13, 8'h04);
        host_wr(4'd12, 8'h01);

        // Events while busy collapse into one extra sweep
        host_wr(4'd5, 8'd17);
        exp_wr(4'd5, 8'd14);
        exp_wr(4'd5, 8'd15);
        s0 = sweeps;
        pulse_frame();          // idx0
        tick();                 // idx1
        pulse_frame();          // captured at idx1
        tick();                 // idx3
        pulse_frame();          // captured at idx3
        host_rd(4'd13, 8'h03);  // captured at idx4: busy, pending
        wait_quiet();
        check("pending_sweeps", sweeps - s0, 2);
        host_rd(4'd13, 8'h00);

        // Target writes mid-sweep: ahead of and behind the scan index
        exp_wr(4'd5, 8'd16);
        exp_wr(4'd7, 8'd14);
        pulse_frame();          // idx0
        tick(); tick();         // idx2
        host_wr(4'd7, 8'd20);   // captured at idx2
        tick(); tick();         // idx5
        host_wr(4'd1, 8'd20);   // captured at idx5
        wait_quiet();
        exp_wr(4'd1, 8'd14);
        exp_wr(4'd5, 8'd17);
        exp_wr(4'd7, 8'd15);
        pulse_frame(); wait_quiet();

        // Reset mid-sweep with pending work
        chk_busy = 1'b0;
        host_wr(4'd9, 8'd20);
        exp_wr(4'd1, 8'd15);
        pulse_frame();          // idx0
        tick();                 // idx1
        pulse_frame();          // pending, returns at idx2
        tick(); tick();         // idx4
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        s0 = sweeps;
        repeat (30) tick();
        check("abort_no_sweep", sweeps - s0, 0);
        check("abort_eq_cs", {31'd0, eq_chipselect}, 0);
        for (int i = 0; i < 12; i++) host_rd(4'(i), 8'd13);
        host_rd(4'd13, 8'h04);
        host_rd(4'd12, 8'h01);
        tick(); tick();

        check("wr_queue_drained", wr_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
